shadow_ctl: RTL
===============

Name: shadow_ctl

Overview:
- Sequences all traffic into the 128 KB 1 MHz slow RAM (banks E0/E1) from a single clk_sys domain.
- Captures CPU writes to banks 00/01 that fall in shadowed video regions, as selected by the SHADOW register (C035), and queues them in a small FIFO.
- Drains the queue into the slow RAM on 1 MHz slots and arbitrates direct CPU accesses to E0/E1 against the queue.
- Stalls the CPU when the queue is full or a direct slow access is waiting for its slot.

Parameters:
- DEPTH, 4, shadow FIFO entries (power of two, 2..16).
- LW, 3, width of fifo_level; must equal log2(DEPTH)+1.

Ports:
- clk_sys  in  1  system clock; all state on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- slow_ce  in  1  one-cycle strobe marking a 1 MHz slow-RAM slot.
- shadow  in  7  SHADOW register value; bit=1 inhibits that region.
- cpu_valid  in  1  CPU bus cycle present this clock; CPU holds all cpu_* inputs while cpu_stall=1.
- cpu_we  in  1  CPU write.
- cpu_bank  in  8  CPU bank.
- cpu_addr  in  16  CPU address.
- cpu_dout  in  8  CPU write data.
- cpu_stall  out  1  combinational; the cycle is not accepted while 1.
- sr_ce  out  1  slow RAM enable for this clock.
- sr_we  out  1  slow RAM write.
- sr_addr  out  17  slow RAM address {bank[0], addr}.
- sr_din  out  8  slow RAM write data.
- busy  out  1  FIFO non-empty (registered).
- fifo_level  out  LW  entries held (registered).

Behaviour:
- Reset (async, reset_n=0):
  - FIFO empty, read/write pointers 0, fifo_level=0, busy=0.
  - cpu_stall=0; sr_ce/sr_we=0; sr_addr/sr_din=0.
  - Queued entries are discarded. A reset mid-drain loses the pending entries; no partial write is issued.
- Acceptance: a CPU cycle is accepted when cpu_valid=1 and cpu_stall=0.
- Shadow hit requires cpu_we=1 and cpu_bank 00 or 01, in one of these regions:
  - 0400-07FF: hit if !shadow[0].
  - 0800-0BFF: hit if !shadow[5].
  - 2000-3FFF:
    - bank 00: hit if !shadow[1].
    - bank 01: hit if !(shadow[1]|shadow[4]).
  - 4000-5FFF:
    - bank 00: hit if !shadow[2].
    - bank 01: hit if !(shadow[2]|shadow[4]).
  - Bank 01, 2000-9FFF: also hit if !shadow[3] (super hi-res; ORed with the rules above).
- Shadow entry: {bank[0], addr, data}. It is pushed on the accepted cycle; the fast-RAM write proceeds elsewhere, unaffected.
- Direct access: cpu_valid=1 with cpu_bank E0 or E1, read or write.
- cpu_stall is asserted when either:
  - a shadow hit occurs while FIFO is full, unless a pop occurs in the same cycle (simultaneous push and pop at full is accepted, level unchanged); or
  - a direct access is pending and not granted this cycle.
- Direct grant: FIFO empty and slow_ce=1 in the same cycle. On grant:
  - sr_ce=1, sr_we=cpu_we, sr_addr={cpu_bank[0], cpu_addr}, sr_din=cpu_dout, cpu_stall=0.
  - Read data comes from slow RAM one clock later (external).
- Drain: slow_ce=1 and FIFO non-empty.
  - sr_ce=1, sr_we=1, sr_addr/sr_din = FIFO head; the head is popped at the clock edge.
  - Drain has priority over direct access, so a direct access to the same address always observes older shadow writes.
- Outside the two cases above, sr_ce=0 and sr_we=0.
- At most one slow-RAM operation per slow_ce strobe.
- Push and pop in the same cycle: level unchanged, order preserved.
- Pointers wrap modulo DEPTH. fifo_level saturates only by design (never >DEPTH, never <0); overflow or underflow is impossible by construction and is asserted in simulation.
- Accesses to other banks, and non-hit writes to banks 00/01: no effect, no stall.
- A shadow change takes effect on the next accepted cycle; already-queued entries still drain.

Test Plan:
- Reset with shadow=00, write 00:0400=AA, 01:2000=55, then pulse slow_ce twice -> sr_we pulses with (00400,AA) then (12000,55); fifo_level goes 2,1,0; cpu_stall stays 0.
- shadow=7F, write 00:0400, 01:5000, 00:2000 -> no push, fifo_level=0, no sr_ce.
- shadow=0x17 (only text2 and SHR enabled), write 01:8000=11 -> push; write 00:2000=22 -> no push.
- No slow_ce, 5 hit writes with DEPTH=4 -> 5th write stalls, fifo_level=4. Then slow_ce -> 5th accepted the same cycle, level stays 4, drain order matches write order.
- FIFO holding 2 entries, read E1:0400 -> stalled through 2 drain slots, granted on the 3rd slow_ce, sr_addr=10400, sr_we=0.
- Assert reset_n=0 with 3 entries queued -> busy=0, fifo_level=0 immediately; a later slow_ce gives no sr_ce.

Source files
------------

// File: rtl/shadow_ctl_if.sv
// rtl/shadow_ctl_if.sv - CPU bus, slow RAM port and status bundle for shadow_ctl
interface shadow_ctl_if #(
    parameter int LW = 3
);
    logic          slow_ce;
    logic [6:0]    shadow;
    logic          cpu_valid;
    logic          cpu_we;
    logic [7:0]    cpu_bank;
    logic [15:0]   cpu_addr;
    logic [7:0]    cpu_dout;
    logic          cpu_stall;
    logic          sr_ce;
    logic          sr_we;
    logic [16:0]   sr_addr;
    logic [7:0]    sr_din;
    logic          busy;
    logic [LW-1:0] fifo_level;

    modport master (
        output slow_ce, shadow, cpu_valid, cpu_we, cpu_bank, cpu_addr, cpu_dout,
        input  cpu_stall, sr_ce, sr_we, sr_addr, sr_din, busy, fifo_level
    );

    modport slave (
        input  slow_ce, shadow, cpu_valid, cpu_we, cpu_bank, cpu_addr, cpu_dout,
        output cpu_stall, sr_ce, sr_we, sr_addr, sr_din, busy, fifo_level
    );
endinterface

// File: rtl/shadow_ctl.sv
// rtl/shadow_ctl.sv - queues shadowed video writes and arbitrates slow RAM slots
module shadow_ctl #(
    parameter int DEPTH = 4,
    parameter int LW    = 3
) (
    input  logic         clk_sys,
    input  logic         reset_n,
    shadow_ctl_if.slave  bus
);
    localparam int PW = LW - 1;

    if (LW != $clog2(DEPTH) + 1) begin : g_bad_lw
        $error("shadow_ctl: LW must equal log2(DEPTH)+1");
    end

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic          busy_q, busy_d;
    logic [24:0]   mem_q [DEPTH];

    logic bank0, bank1, in_txt1, in_txt2, in_hgr1, in_hgr2, in_shr;
    logic hit, push_req, direct, empty, full, drain, grant, stall_raw, push, pop;
    logic [24:0] head;

    // bit 6 of SHADOW (I/O/LC inhibit) has no bearing on video shadowing
    logic unused_shadow;
    assign unused_shadow = bus.shadow[6];

    assign bank0   = (bus.cpu_bank == 8'h00);
    assign bank1   = (bus.cpu_bank == 8'h01);
    assign in_txt1 = (bus.cpu_addr[15:10] == 6'b000001);
    assign in_txt2 = (bus.cpu_addr[15:10] == 6'b000010);
    assign in_hgr1 = (bus.cpu_addr[15:13] == 3'b001);
    assign in_hgr2 = (bus.cpu_addr[15:13] == 3'b010);
    assign in_shr  = (bus.cpu_addr >= 16'h2000) && (bus.cpu_addr <= 16'h9FFF);

    assign hit = bus.cpu_we && (bank0 || bank1) &&
                 ((in_txt1 && !bus.shadow[0]) ||
                  (in_txt2 && !bus.shadow[5]) ||
                  (in_hgr1 && !(bus.shadow[1] || (bank1 && bus.shadow[4]))) ||
                  (in_hgr2 && !(bus.shadow[2] || (bank1 && bus.shadow[4]))) ||
                  (bank1 && in_shr && !bus.shadow[3]));

    assign push_req = bus.cpu_valid && hit;
    assign direct   = bus.cpu_valid && (bus.cpu_bank[7:1] == 7'b1110000);
    assign empty    = (level_q == '0);
    assign full     = (level_q == LW'(DEPTH));
    assign head     = mem_q[rd_ptr_q];

    // Drain wins the slot so a direct access sees every older shadow write.
    assign drain     = reset_n && bus.slow_ce && !empty;
    assign grant     = reset_n && direct && empty && bus.slow_ce;
    assign stall_raw = (push_req && full && !drain) || (direct && !grant);
    assign push      = reset_n && push_req && !stall_raw;
    assign pop       = drain;

    always_comb begin
        bus.cpu_stall = reset_n && stall_raw;
        bus.sr_ce     = 1'b0;
        bus.sr_we     = 1'b0;
        bus.sr_addr   = '0;
        bus.sr_din    = '0;
        if (drain) begin
            bus.sr_ce   = 1'b1;
            bus.sr_we   = 1'b1;
            bus.sr_addr = head[24:8];
            bus.sr_din  = head[7:0];
        end else if (grant) begin
            bus.sr_ce   = 1'b1;
            bus.sr_we   = bus.cpu_we;
            bus.sr_addr = {bus.cpu_bank[0], bus.cpu_addr};
            bus.sr_din  = bus.cpu_dout;
        end
    end

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
        level_d  = level_q;
        if (push && !pop) begin
            level_d = level_q + LW'(1);
        end else if (pop && !push) begin
            level_d = level_q - LW'(1);
        end
        busy_d = (level_d != '0);
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            busy_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            busy_q   <= busy_d;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {bus.cpu_bank[0], bus.cpu_addr, bus.cpu_dout};
        end
    end

    assign bus.busy       = busy_q;
    assign bus.fifo_level = level_q;

    always @(posedge clk_sys) begin
        if (reset_n) begin
            assert (!(push && !pop && full));
            assert (!(pop && empty));
        end
    end
endmodule
